// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg: opcodes, id_ctrl bit positions, alu_op encodings, control decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_MSB = 1;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  // The all-zero word is a nop even though its opcode field is R-type.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [31:0] instr);
    logic [CTRL_W-1:0] ctrl;
    ctrl = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        if (instr != 32'd0) begin
          ctrl[CTRL_REG_DST]   = 1'b1;
          ctrl[CTRL_REG_WRITE] = 1'b1;
          ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_FUNCT;
        end
      end
      OP_LW: begin
        ctrl[CTRL_ALU_SRC]    = 1'b1;
        ctrl[CTRL_MEM_TO_REG] = 1'b1;
        ctrl[CTRL_REG_WRITE]  = 1'b1;
        ctrl[CTRL_MEM_READ]   = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      OP_SW: begin
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_MEM_WRITE] = 1'b1;
      end
      OP_BEQ: begin
        ctrl[CTRL_BRANCH] = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_SUB;
      end
      OP_ADDI: begin
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
      end
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_pipe_stage_reg_file.sv
// ============================================================================
// reg_file: 32-entry register file, reset clear, r0 hardwired, write bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // A write in the same cycle as a read of that register is returned directly.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
  end

endmodule

`default_nettype wire

// File: rtl/id_pipe_stage.sv
// ============================================================================
// id_pipe_stage: MIPS ID stage - IF/ID register, regfile, decode, hazards.
// Option ID_BRANCH_FWD_EN forwards a MEM ALU result into beq compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_pipe_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     if_pc_plus4,
  input  logic [31:0]           if_instr,
  output logic                  pc_en,
  output logic                  branch_taken,
  output logic [ADDR_W-1:0]     branch_address,
  output logic                  jump,
  output logic [ADDR_W-1:0]     jump_address,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  input  logic                  mem_mem_read,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  input  logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     id_reg1_data,
  output logic [DATA_W-1:0]     id_reg2_data,
  output logic [DATA_W-1:0]     id_imm,
  output logic [REG_ADDR_W-1:0] id_rs,
  output logic [REG_ADDR_W-1:0] id_rt,
  output logic [REG_ADDR_W-1:0] id_rd,
  output logic [CTRL_W-1:0]     id_ctrl
);

  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_plus4;
  logic [5:0]        opcode;
  logic [CTRL_W-1:0] ctrl;
  logic              is_beq, is_j, uses_rt;
  logic              stall, flush;
  logic              load_use, beq_ex_dep, beq_mem_load, beq_mem_alu_stall;
  logic              mem_alu_writer;
  logic [DATA_W-1:0] cmp_a, cmp_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr    <= '0;
      pc_plus4 <= '0;
    end else if (!stall) begin
      instr    <= flush ? 32'd0 : if_instr;
      pc_plus4 <= if_pc_plus4;
    end
  end

  reg_file #(.DATA_W(DATA_W)) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data),
    .raddr1 (id_rs),
    .raddr2 (id_rt),
    .rdata1 (id_reg1_data),
    .rdata2 (id_reg2_data)
  );

  assign opcode  = instr[31:26];
  assign id_rs   = instr[25:21];
  assign id_rt   = instr[20:16];
  assign id_rd   = instr[15:11];
  assign id_imm  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign ctrl    = decode_ctrl(instr);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_beq;

  assign branch_address = pc_plus4 + {id_imm[ADDR_W-3:0], 2'b00};
  assign jump_address   = {instr[ADDR_W-3:0], 2'b00};

  assign load_use = ex_mem_read && (ex_write_reg != '0) &&
                    ((ex_write_reg == id_rs) || (uses_rt && (ex_write_reg == id_rt)));
  assign beq_ex_dep = is_beq && ex_reg_write && (ex_write_reg != '0) &&
                      ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
  assign beq_mem_load = is_beq && mem_mem_read && (mem_write_reg != '0) &&
                        ((mem_write_reg == id_rs) || (mem_write_reg == id_rt));
  assign mem_alu_writer = mem_reg_write && (mem_write_reg != '0) && !mem_mem_read;

`ifdef ID_BRANCH_FWD_EN
  assign beq_mem_alu_stall = 1'b0;
  assign cmp_a = (mem_alu_writer && (mem_write_reg == id_rs)) ? mem_alu_result : id_reg1_data;
  assign cmp_b = (mem_alu_writer && (mem_write_reg == id_rt)) ? mem_alu_result : id_reg2_data;
`else
  // Without forwarding, wait until the writer reaches WB and the regfile bypass.
  logic unused_mem_alu_result;
  assign unused_mem_alu_result = ^mem_alu_result;
  assign beq_mem_alu_stall = is_beq && mem_alu_writer &&
                             ((mem_write_reg == id_rs) || (mem_write_reg == id_rt));
  assign cmp_a = id_reg1_data;
  assign cmp_b = id_reg2_data;
`endif

  assign stall = load_use || beq_ex_dep || beq_mem_load || beq_mem_alu_stall;

  assign pc_en        = !stall;
  assign branch_taken = !stall && is_beq && (cmp_a == cmp_b);
  assign jump         = !stall && is_j;
  assign flush        = branch_taken || jump;
  assign id_ctrl      = stall ? '0 : ctrl;

endmodule

`default_nettype wire
